// File: rtl/seqdiv16.sv
// Sequential 16-bit restoring divider: one quotient bit per clock, signed or
// unsigned, with a registered one-cycle completion pulse and divide-by-zero flag.
module seqdiv16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic        work,
  output logic [15:0] result,
  output logic        rdy,
  output logic        divbyzero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        s1_q;
  logic        s2_q;
  logic        zero_q;
  logic [16:0] rem_q;
  logic [15:0] dvd_q;
  logic [15:0] dvs_q;
  logic [3:0]  cnt_q;

  logic [16:0] shifted;
  logic [16:0] trial;
  logic [15:0] mag1;
  logic [15:0] mag2;

  // Magnitudes are taken as unsigned, so |-32768| comes out as 0x8000.
  assign mag1    = (num1[15] & mode) ? (16'd0 - num1) : num1;
  assign mag2    = (num2[15] & mode) ? (16'd0 - num2) : num2;
  assign shifted = {rem_q[15:0], dvd_q[15]};
  assign trial   = shifted - {1'b0, dvs_q};

  assign work = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_q == 4'd0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      zero_q    <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
      rdy       <= 1'b0;
      divbyzero <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s1_q   <= num1[15] & mode;
            s2_q   <= num2[15] & mode;
            zero_q <= (num2 == 16'd0);
            dvd_q  <= mag1;
            dvs_q  <= mag2;
            rem_q  <= '0;
            cnt_q  <= 4'd15;
          end
        end
        RUN: begin
          // A borrow out of the trial subtraction means the divisor did not fit.
          if (!trial[16]) begin
            rem_q <= trial;
            dvd_q <= {dvd_q[14:0], 1'b1};
          end else begin
            rem_q <= shifted;
            dvd_q <= {dvd_q[14:0], 1'b0};
          end
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        FINISH: begin
          rdy <= 1'b1;
          if (zero_q) begin
            result    <= 16'hFFFF;
            divbyzero <= 1'b1;
          end else begin
            result    <= (s1_q ^ s2_q) ? (16'd0 - dvd_q) : dvd_q;
            divbyzero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
